temporizador_decrescente: RTL and testbench
===========================================

TEMPORIZADOR_DECRESCENTE -- requirements
Module: temporizador_decrescente

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the count value.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: clr  input  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 Port: start  input  1  request to load load_val and begin counting down.
REQ-005 Port: load_val  input  WIDTH  initial/reload count, sampled only when start is accepted.
REQ-006 Port: auto_reload  input  1  when 1, reload the latched value after each terminal count.
REQ-007 Port: pause  input  1  freezes q while counting.
REQ-008 Port: stop  input  1  aborts counting, returns to idle.
REQ-009 Port: q  output  WIDTH  current count value, registered.
REQ-010 Port: busy  output  1  high while in COUNT state.
REQ-011 Port: done  output  1  one-cycle terminal-count pulse, registered.

Function
REQ-012 The block SHALL implement three states: IDLE, COUNT, DONE; busy=1 only in COUNT, done=1 only in DONE.
REQ-013 IDLE, start=1, load_val!=0: next edge q<=load_val, reload register<=load_val, state<=COUNT.
REQ-014 IDLE, start=1, load_val==0: next edge state<=DONE, q stays 0, reload register<=0.
REQ-015 COUNT, pause=0, q>1: q<=q-1 each edge.
REQ-016 COUNT, pause=0, q==1: q<=0, state<=DONE; done thus coincides with q==0.
REQ-017 COUNT, pause=1: q and state hold.
REQ-018 DONE, auto_reload=1, reload register!=0: next edge q<=reload register, state<=COUNT.
REQ-019 DONE otherwise: next edge state<=IDLE, q stays 0.
REQ-020 Latency: start accepted at edge k with load_val=N>0 -> done high for exactly the cycle after edge k+N; auto-reload period is N+1 cycles.
REQ-021 start SHALL be ignored in COUNT and DONE; load_val changes after acceptance have no effect.
REQ-022 stop=1 in COUNT or DONE: next edge q<=0, state<=IDLE, no done pulse; stop has priority over pause, start and auto_reload.
REQ-023 stop=1 and start=1 in IDLE: stop wins, state remains IDLE.
REQ-024 q SHALL never wrap below 0; no decrement occurs from q==0.
REQ-025 All arithmetic SHALL be WIDTH-bit unsigned; maximum load 2^WIDTH-1 counts correctly.

Reset
REQ-026 clr=1 SHALL immediately, independent of clk, force state=IDLE, q=0, reload register=0, busy=0, done=0.
REQ-027 Reset asserted mid-count SHALL abort without a done pulse; after release the block waits for a new start.
REQ-028 First active edge after clr falls SHALL evaluate inputs normally.

Structure
REQ-029 State encodings (IDLE=2'b00, COUNT=2'b01, DONE=2'b10) SHALL be constants in a shared definitions file included by RTL and bench.
REQ-030 One sub-module is natural: contador_decrescente_nucleo, WIDTH-bit down counter with load, enable and is-one flag; FSM stays in the top.
REQ-031 Outputs busy and done SHALL be decoded from the registered state only.

Verification
REQ-032 clr=1 for 20 ns then 0; start with load_val=5 -> q=5,4,3,2,1,0 on consecutive edges, done high one cycle with q=0, then IDLE.
REQ-033 auto_reload=1, load_val=3 -> q sequence 3,2,1,0,3,2,1,0...; done every 4 cycles; busy low only during DONE.
REQ-034 load_val=6, pause=1 for 3 cycles when q=4 -> q holds 4 three cycles; done delayed by exactly 3 cycles.
REQ-035 stop=1 at q=2 -> q=0, IDLE next edge, done never asserted; start pulse during COUNT has no effect on q.
REQ-036 start with load_val=0 -> one done pulse, q stays 0; load_val=15 (WIDTH=4) -> done 15 cycles after start, no wrap.
REQ-037 clr pulse asserted between clock edges mid-count -> q=0, busy=0 immediately, before next clk edge.

Source files
------------

// File: rtl/temporizador_decrescente_pkg.sv
// Shared definitions for the down-counting timer: FSM state encoding
// used by the RTL and by the testbench.
package temporizador_decrescente_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/temporizador_decrescente_nucleo.sv
// WIDTH-bit down counter core: synchronous clear, load, enable and an
// is-one flag. Priority is clear > load > decrement. The count never
// decrements from zero, so it can never wrap.
module contador_decrescente_nucleo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  // Count register: async reset to zero, then clear/load/decrement.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_data;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/temporizador_decrescente.sv
// Down-counting timer with start/stop/pause and optional auto-reload.
// The FSM (IDLE/COUNT/DONE) lives here; the count register lives in the
// counter core. busy and done are decoded from the registered state only,
// so done rises exactly when q reaches zero and lasts one cycle.
module temporizador_decrescente
  import temporizador_decrescente_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_t           st;
  logic [WIDTH-1:0] reload;
  logic             cnt_clear;
  logic             cnt_load;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_data;
  logic             cnt_is_one;

  contador_decrescente_nucleo #(
    .WIDTH(WIDTH)
  ) u_nucleo (
    .clk      (clk),
    .clr      (clr),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_data(cnt_data),
    .en       (cnt_en),
    .count    (q),
    .is_one   (cnt_is_one)
  );

  // Counter control derived from the current state and inputs; stop always wins.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_data  = reload;
    case (st)
      IDLE: begin
        if (!stop && start && (load_val != '0)) begin
          cnt_load = 1'b1;
          cnt_data = load_val;
        end
      end
      COUNT: begin
        if (stop) begin
          cnt_clear = 1'b1;
        end else if (!pause) begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (stop) begin
          cnt_clear = 1'b1;
        end else if (auto_reload && (reload != '0)) begin
          cnt_load = 1'b1;
        end
      end
      default: cnt_clear = 1'b1;
    endcase
  end

  // FSM and reload register; start is only accepted in IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st     <= IDLE;
      reload <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (!stop && start) begin
            reload <= load_val;
            st     <= (load_val != '0) ? COUNT : DONE;
          end
        end
        COUNT: begin
          if (stop) begin
            st <= IDLE;
          end else if (!pause && cnt_is_one) begin
            st <= DONE;
          end
        end
        DONE: begin
          if (stop) begin
            st <= IDLE;
          end else if (auto_reload && (reload != '0)) begin
            st <= COUNT;
          end else begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign busy  = (st == COUNT);
  assign done  = (st == DONE);
  assign state = st;

endmodule

// File: tb/tb_temporizador_decrescente.sv
// Self-checking bench for temporizador_decrescente: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against
// a behavioural model of the timer.
module tb_temporizador_decrescente;
  import temporizador_decrescente_pkg::*;

  localparam int W = 4;

  // Clock / reset
  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic         pause = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  always #5 clk = ~clk;

  temporizador_decrescente #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .pause      (pause),
    .stop       (stop),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Behavioural model: what q/busy/done must be after each edge.
  int m_q      = 0;
  int m_reload = 0;
  bit m_busy   = 0;
  bit m_done   = 0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_q <= 0; m_busy <= 0; m_done <= 0; m_reload <= 0;
    end else if (m_busy) begin
      if (stop) begin
        m_q <= 0; m_busy <= 0;
      end else if (!pause) begin
        m_q <= m_q - 1;
        if (m_q == 1) begin
          m_busy <= 0; m_done <= 1;
        end
      end
    end else if (m_done) begin
      m_done <= 0;
      if (!stop && auto_reload && m_reload != 0) begin
        m_q <= m_reload; m_busy <= 1;
      end else begin
        m_q <= 0;
      end
    end else if (!stop && start) begin
      m_reload <= int'(load_val);
      if (load_val != 0) begin
        m_q <= int'(load_val); m_busy <= 1;
      end else begin
        m_done <= 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !clr) begin
      check("cmp_q", int'(q), m_q);
      check("cmp_busy", int'(busy), int'(m_busy));
      check("cmp_done", int'(done), int'(m_done));
      check("cmp_state", int'(state),
            m_busy ? int'(COUNT) : (m_done ? int'(DONE) : int'(IDLE)));
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int v);
    start = 1'b1;
    load_val = W'(v);
    cyc();
    start = 1'b0;
    load_val = W'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input string name, input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      cyc();
      n++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s: timeout after %0d cycles, expected done", name, n);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int exp5[6] = '{5, 4, 3, 2, 1, 0};
    int exp3[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
    int n;
    int total;

    // Reset: 20 ns pulse
    #1 clr = 1'b1;
    #9;
    check("reset_q", int'(q), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    #11 clr = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Basic count from 5
    do_start(5);
    for (int i = 0; i < 6; i++) begin
      check("seq5_q", int'(q), exp5[i]);
      check("seq5_done", int'(done), (i == 5) ? 1 : 0);
      if (i < 5) cyc();
    end
    cyc();
    check("seq5_idle_busy", int'(busy), 0);
    check("seq5_idle_done", int'(done), 0);

    // Auto-reload period N+1
    auto_reload = 1'b1;
    do_start(3);
    for (int i = 0; i < 8; i++) begin
      check("auto_q", int'(q), exp3[i]);
      check("auto_done", int'(done), (i % 4 == 3) ? 1 : 0);
      check("auto_busy", int'(busy), (i % 4 == 3) ? 0 : 1);
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    auto_reload = 1'b0;
    check("auto_stop_q", int'(q), 0);
    check("auto_stop_busy", int'(busy), 0);
    cyc();

    // Pause for 3 cycles at q=4
    do_start(6);
    cyc();
    cyc();
    check("pause_pre_q", int'(q), 4);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("pause_hold_q", int'(q), 4);
    end
    pause = 1'b0;
    wait_done("pause_lat", 40, n);
    total = 2 + 3 + n;
    check("pause_latency", total, 9);
    cyc();

    // Start ignored during COUNT, stop at q=2
    do_start(5);
    start = 1'b1;
    load_val = 4'd9;
    cyc();
    start = 1'b0;
    check("ign_start_q", int'(q), 4);
    cyc();
    cyc();
    check("stop_pre_q", int'(q), 2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_q", int'(q), 0);
    check("stop_busy", int'(busy), 0);
    check("stop_done", int'(done), 0);
    cyc();
    check("stop_done_after", int'(done), 0);

    // stop and start together in IDLE
    stop = 1'b1;
    do_start(7);
    stop = 1'b0;
    check("stop_start_busy", int'(busy), 0);

    // load 0: immediate done pulse
    do_start(0);
    check("zero_done", int'(done), 1);
    check("zero_q", int'(q), 0);
    cyc();
    check("zero_done_end", int'(done), 0);

    // load 15: full range, no wrap
    do_start(15);
    check("max_q", int'(q), 15);
    wait_done("max_lat", 40, n);
    check("max_latency", n, 15);
    check("max_done_q", int'(q), 0);
    cyc();
    check("max_nowrap_q", int'(q), 0);

    // Async clear between edges mid-count
    do_start(9);
    cyc();
    cyc();
    #1 clr = 1'b1;
    #1;
    check("aclr_q", int'(q), 0);
    check("aclr_busy", int'(busy), 0);
    check("aclr_done", int'(done), 0);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("aclr_after_done", int'(done), 0);
    end

    // Randomized traffic checked by the per-cycle compare
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 19) == 0);
      pause = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 5))
        0: load_val = '0;
        1: load_val = '1;
        2: load_val = W'(1);
        default: load_val = W'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
      cyc();
      if ($urandom_range(0, 99) == 0) begin
        #1 clr = 1'b1;
        #1 clr = 1'b0;
      end
    end
    start = 1'b0;
    stop = 1'b0;
    pause = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
